// File: rtl/sonic_vc_pkg.sv
// Shared definitions for the sonic virtual-channel datapath: channel width
// helper and the field layout of a packed Avalon-ST beat payload.
package sonic_vc_pkg;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Payload layout, LSB first: sop, error, eop, empty, data.
    localparam int SOP_LSB = 0;
    localparam int ERR_LSB = 1;

    function automatic int eop_lsb(input int err_w);
        return ERR_LSB + err_w;
    endfunction

    function automatic int empty_lsb(input int err_w);
        return eop_lsb(err_w) + 1;
    endfunction

    function automatic int data_lsb(input int empty_w, input int err_w);
        return empty_lsb(err_w) + empty_w;
    endfunction

    function automatic int payload_w(input int data_w, input int empty_w, input int err_w);
        return data_w + empty_w + err_w + 2;
    endfunction

endpackage

// File: rtl/sonic_vc_skid_buffer.sv
// Two-entry skid buffer with a registered in_ready; sustains one beat per
// cycle and keeps out_data stable while stalled.
module sonic_vc_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q, ready_d;
    logic             push, pop;

    assign push = in_valid && ready_q;
    assign pop  = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (skid_valid_q) begin
            // Full: ready is low, so only a drain can happen.
            if (pop) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid_q) begin
            if (push && pop) begin
                main_d = in_data;
            end else if (push) begin
                skid_valid_d = 1'b1;
                skid_d       = in_data;
            end else if (pop) begin
                main_valid_d = 1'b0;
            end
        end else if (push) begin
            main_valid_d = 1'b1;
            main_d       = in_data;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            ready_q      <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            ready_q      <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/sonic_vc_rr_packet_mux.sv
// Packet-aware round-robin Avalon-ST mux: holds each grant from SOP to EOP
// and tags every output beat with its source index.
module sonic_vc_rr_packet_mux
    import sonic_vc_pkg::*;
#(
    parameter  int NUM_IN  = 4,
    parameter  int DATA_W  = 128,
    parameter  int EMPTY_W = 4,
    parameter  int ERR_W   = 1,
    localparam int CH_W    = ch_w(NUM_IN)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_IN-1:0]         in_valid,
    output logic [NUM_IN-1:0]         in_ready,
    input  logic [NUM_IN*DATA_W-1:0]  in_data,
    input  logic [NUM_IN-1:0]         in_sop,
    input  logic [NUM_IN-1:0]         in_eop,
    input  logic [NUM_IN*EMPTY_W-1:0] in_empty,
    input  logic [NUM_IN*ERR_W-1:0]   in_error,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [EMPTY_W-1:0]        out_empty,
    output logic [ERR_W-1:0]          out_error,
    output logic [CH_W-1:0]           out_channel,
    output logic                      busy
);

    localparam int EOP_LSB   = eop_lsb(ERR_W);
    localparam int EMPTY_LSB = empty_lsb(ERR_W);
    localparam int DATA_LSB  = data_lsb(EMPTY_W, ERR_W);
    localparam int PAYLOAD_W = payload_w(DATA_W, EMPTY_W, ERR_W);
    localparam int BUF_W     = PAYLOAD_W + CH_W;

    logic              locked_q, locked_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic              cand_found;
    logic [CH_W-1:0]   cand_idx;
    logic [CH_W:0]     idx;
    logic [CH_W-1:0]   active;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic              sel_sop, sel_eop;
    logic [EMPTY_W-1:0] sel_empty;
    logic [ERR_W-1:0]  sel_error;
    logic              accept;

    logic              buf_in_ready;
    logic [BUF_W-1:0]  buf_in_data, buf_out_data;

    // Search downward so the lowest offset from rr_ptr (highest priority) wins.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        idx        = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + (CH_W + 1)'(k);
            if (idx >= (CH_W + 1)'(NUM_IN)) begin
                idx = idx - (CH_W + 1)'(NUM_IN);
            end
            if (in_valid[idx[CH_W-1:0]]) begin
                cand_found = 1'b1;
                cand_idx   = idx[CH_W-1:0];
            end
        end
    end

    assign active    = locked_q ? grant_q : cand_idx;
    assign sel_valid = locked_q ? in_valid[grant_q] : cand_found;
    assign accept    = sel_valid && buf_in_ready;

    always_comb begin
        sel_data  = '0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        sel_empty = '0;
        sel_error = '0;
        in_ready  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (CH_W'(i) == active) begin
                sel_data  = in_data[i*DATA_W +: DATA_W];
                sel_sop   = in_sop[i];
                sel_eop   = in_eop[i];
                sel_empty = in_empty[i*EMPTY_W +: EMPTY_W];
                sel_error = in_error[i*ERR_W +: ERR_W];
            end
        end
        if (locked_q || cand_found) begin
            in_ready[active] = buf_in_ready;
        end
    end

    assign buf_in_data = {active, sel_data, sel_empty, sel_eop, sel_error, sel_sop};

    always_comb begin
        locked_d = locked_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (sel_eop) begin
                locked_d = 1'b0;
                rr_ptr_d = (active == CH_W'(NUM_IN - 1)) ? '0 : active + CH_W'(1);
            end else begin
                locked_d = 1'b1;
                grant_d  = active;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked_q <= 1'b0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            locked_q <= locked_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    sonic_vc_skid_buffer #(
        .WIDTH(BUF_W)
    ) u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (sel_valid),
        .in_ready (buf_in_ready),
        .in_data  (buf_in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (buf_out_data)
    );

    assign out_sop     = buf_out_data[SOP_LSB];
    assign out_error   = buf_out_data[ERR_LSB +: ERR_W];
    assign out_eop     = buf_out_data[EOP_LSB];
    assign out_empty   = buf_out_data[EMPTY_LSB +: EMPTY_W];
    assign out_data    = buf_out_data[DATA_LSB +: DATA_W];
    assign out_channel = buf_out_data[PAYLOAD_W +: CH_W];
    assign busy        = locked_q;

endmodule

// File: tb/tb_sonic_vc_rr_packet_mux.sv
// Randomized bench for sonic_vc_rr_packet_mux: queue-based reference of the
// arbitration rules and the two-beat output buffer, plus directed phases.
module tb_sonic_vc_rr_packet_mux;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int EW = 4;
  localparam int RW = 2;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_sop = '0;
  logic [N-1:0]    in_eop = '0;
  logic [N*EW-1:0] in_empty = '0;
  logic [N*RW-1:0] in_error = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic            out_sop;
  logic            out_eop;
  logic [EW-1:0]   out_empty;
  logic [RW-1:0]   out_error;
  logic [CW-1:0]   out_channel;
  logic            busy;

  always #5 clk = ~clk;

  sonic_vc_rr_packet_mux #(
    .NUM_IN (N),
    .DATA_W (DW),
    .EMPTY_W(EW),
    .ERR_W  (RW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_empty   (in_empty),
    .in_error   (in_error),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_empty  (out_empty),
    .out_error  (out_error),
    .out_channel(out_channel),
    .busy       (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [DW-1:0] data;
    logic [EW-1:0] empty;
    logic [RW-1:0] error;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t exp_q[$];
  bit    m_locked;
  int    m_grant;
  int    m_ptr;

  int            beat_idx[N];
  int            pkt_len[N];
  int            seq_no[N];
  int            vprob[N];
  int            len_lo[N];
  int            len_hi[N];
  int            rprob;
  int            fair_cyc = -1;
  logic [DW-1:0] cur_data[N];
  logic [EW-1:0] cur_empty[N];
  logic [RW-1:0] cur_error[N];

  task automatic next_beat(input int i);
    if (beat_idx[i] == 0) pkt_len[i] = $urandom_range(len_lo[i], len_hi[i]);
    cur_data[i]  = {32'($urandom()), 8'(i), 24'(seq_no[i])};
    cur_empty[i] = EW'($urandom());
    cur_error[i] = RW'($urandom());
    seq_no[i]++;
  endtask

  task automatic set_cfg(input int vp, input int lo, input int hi);
    for (int i = 0; i < N; i++) begin
      vprob[i]  = vp;
      len_lo[i] = lo;
      len_hi[i] = hi;
    end
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance the model.
  task automatic cycle();
    beat_t        b;
    int           act;
    int           c;
    bit           sel;
    bit           buf_rdy;
    bit           pop;
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) begin
      in_valid[i]           = ($urandom_range(1, 100) <= vprob[i]);
      in_sop[i]             = (beat_idx[i] == 0);
      in_eop[i]             = (beat_idx[i] == pkt_len[i] - 1);
      in_data[i*DW +: DW]   = cur_data[i];
      in_empty[i*EW +: EW]  = cur_empty[i];
      in_error[i*RW +: RW]  = cur_error[i];
    end
    out_ready = ($urandom_range(1, 100) <= rprob);
    @(negedge clk);
    buf_rdy = (exp_q.size() < 2);
    act = -1;
    sel = 1'b0;
    if (m_locked) begin
      act = m_grant;
      sel = in_valid[m_grant];
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (act < 0 && in_valid[c]) begin
          act = c;
          sel = 1'b1;
        end
      end
    end
    exp_rdy = '0;
    if (act >= 0) exp_rdy[act] = buf_rdy;
    check("in_ready", in_ready, exp_rdy);
    check("busy", busy, m_locked);
    check("out_valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("out_channel", out_channel, exp_q[0].ch);
      check("out_data", out_data, exp_q[0].data);
      check("out_sop", out_sop, exp_q[0].sop);
      check("out_eop", out_eop, exp_q[0].eop);
      check("out_empty", out_empty, exp_q[0].empty);
      check("out_error", out_error, exp_q[0].error);
    end
    if (fair_cyc >= 0) begin
      if (fair_cyc >= 1) begin
        check("fair_valid", out_valid, 1);
        check("fair_ch", out_channel, (fair_cyc - 1) % N);
      end
      fair_cyc++;
    end
    pop = out_ready && (exp_q.size() > 0);
    if (pop) void'(exp_q.pop_front());
    if (sel && buf_rdy) begin
      b.ch    = CW'(act);
      b.data  = cur_data[act];
      b.empty = cur_empty[act];
      b.error = cur_error[act];
      b.sop   = in_sop[act];
      b.eop   = in_eop[act];
      exp_q.push_back(b);
      if (b.eop) begin
        m_locked      = 1'b0;
        m_ptr         = (act + 1) % N;
        beat_idx[act] = 0;
      end else begin
        m_locked      = 1'b1;
        m_grant       = act;
        beat_idx[act] = beat_idx[act] + 1;
      end
      next_beat(act);
    end
    @(posedge clk);
    #1;
  endtask

  // Asserts reset from a mid-cycle point; outputs must clear without a clock.
  task automatic do_reset();
    in_valid  = '0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_channel", out_channel, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sop", out_sop, 0);
    check("rst_out_eop", out_eop, 0);
    check("rst_out_empty", out_empty, 0);
    check("rst_out_error", out_error, 0);
    check("rst_in_ready", in_ready, 0);
    exp_q.delete();
    m_locked = 1'b0;
    m_grant  = 0;
    m_ptr    = 0;
    for (int i = 0; i < N; i++) begin
      beat_idx[i] = 0;
      next_beat(i);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) seq_no[i] = 0;
    rprob = 100;
    set_cfg(100, 1, 1);
    do_reset();

    // All inputs stream single-beat packets: strict rotation, no bubbles.
    fair_cyc = 0;
    repeat (20) cycle();
    fair_cyc = -1;

    // Long packet on input 2 competing with input 0.
    set_cfg(0, 1, 1);
    vprob[0] = 100;
    vprob[2] = 100;
    len_lo[2] = 5;
    len_hi[2] = 5;
    repeat (30) cycle();

    // Backpressure: a fixed 3-cycle stall, then random stalls.
    set_cfg(100, 1, 4);
    rprob = 100;
    repeat (6) cycle();
    rprob = 0;
    repeat (3) cycle();
    rprob = 100;
    repeat (6) cycle();
    rprob = 50;
    repeat (200) cycle();

    // Input 1 bubbles mid-packet while input 3 is always pending.
    set_cfg(0, 1, 1);
    vprob[1] = 40;
    len_lo[1] = 6;
    len_hi[1] = 6;
    vprob[3] = 100;
    rprob = 100;
    repeat (80) cycle();

    // Reset with two beats buffered and a packet in flight.
    set_cfg(100, 3, 5);
    rprob = 0;
    for (int t = 0; t < 10 && exp_q.size() < 2; t++) cycle();
    set_cfg(100, 1, 1);
    rprob = 100;
    do_reset();
    fair_cyc = 0;
    repeat (12) cycle();
    fair_cyc = -1;

    // Fully random traffic with random sideband.
    repeat (15) begin
      for (int i = 0; i < N; i++) begin
        vprob[i]  = $urandom_range(20, 100);
        len_lo[i] = 1;
        len_hi[i] = $urandom_range(1, 6);
      end
      rprob = $urandom_range(30, 100);
      repeat (100) cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
